bi_bus_arbiter: RTL and testbench
=================================

BI_BUS_ARBITER -- requirements
Module: bi_bus_arbiter

Interface
REQ-001 SHALL have parameter TURN_CYCLES, default 2: idle turnaround cycles inserted on every direction change; legal range 1..15.
REQ-002 SHALL have parameter MAX_BURST, default 8: maximum consecutive grant cycles while the opposite side waits; legal range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port req_a, input, 1: side A requests to drive the shared line (A->B).
REQ-006 SHALL have port req_b, input, 1: side B requests to drive the shared line (B->A).
REQ-007 SHALL have port gnt_a, output, 1: side A granted; registered.
REQ-008 SHALL have port gnt_b, output, 1: side B granted; registered.
REQ-009 SHALL have port dir, output, 1: buffer direction control, connects to bi_buffer ctrl; 1 = A drives, 0 = B drives; registered.
REQ-010 SHALL have port oe, output, 1: line enable; 0 = both sides tri-stated; registered.
REQ-011 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, TURN, GRANT_A, GRANT_B.
REQ-013 IDLE: oe=0, gnt_a=gnt_b=0, dir holds its last value.
REQ-014 IDLE, single request: if the requester's direction equals dir, go to its GRANT state; otherwise set dir to the new direction and go to TURN.
REQ-015 IDLE, req_a and req_b in the same cycle: grant the side not granted last (round-robin); after reset, A wins first.
REQ-016 TURN: oe=0, no grants; dir already updated; stay exactly TURN_CYCLES cycles, then enter the GRANT state matching dir.
REQ-017 GRANT_A: gnt_a=1, oe=1, dir=1. GRANT_B: gnt_b=1, oe=1, dir=0.
REQ-018 Grant latency from IDLE: gnt rises 1 cycle after req is sampled with no direction change, and 1+TURN_CYCLES cycles after with a direction change.
REQ-019 GRANT_x, own request deasserted: grant falls next edge; go to TURN toward the other side if its req is high, else to IDLE.
REQ-020 GRANT_x: a burst counter SHALL count granted cycles; it clears on entry to every GRANT state.
REQ-021 gnt and oe SHALL never be high during TURN; gnt_a and gnt_b SHALL never be high together.
REQ-022 Request glitches during TURN SHALL NOT abort the turnaround; if the target side has dropped its req at TURN end, go to IDLE.

Reset
REQ-023 rst high at a clock edge SHALL force state=IDLE, gnt_a=gnt_b=0, oe=0, dir=0, busy=0, counters=0, and round-robin pointer to "B last"; this applies mid-grant and mid-turnaround.
REQ-024 The first state decision SHALL occur on the first edge with rst low.

Configuration
REQ-025 With macro BI_ARB_BURST_LIMIT_EN defined: in GRANT_x, when the burst count reaches MAX_BURST and the other side's req is high, the grant SHALL be revoked next edge and the block SHALL go to TURN toward the other side, even if the holder still requests.
REQ-026 Without BI_ARB_BURST_LIMIT_EN: a grant SHALL be held for as long as its req stays high; the burst counter and MAX_BURST SHALL be unused.

Structure
REQ-027 State encodings (2-bit), DIR_A=1 and DIR_B=0 constants SHALL live in shared package bi_arb_pkg.
REQ-028 A single sub-module bi_arb_cnt (load/decrement/zero-flag down-counter) SHALL be used for both the turnaround count and the burst count.

Verification
REQ-029 After reset, req_b=1 -> TURN for 2 cycles with oe=0 and dir=0, then gnt_b=1 and oe=1 on cycle 3.
REQ-030 After reset, req_a and req_b rise together -> TURN for 2 cycles with dir=1, then gnt_a; drop req_a -> gnt_a low next edge, TURN for 2 cycles, then gnt_b.
REQ-031 Macro defined, MAX_BURST=8, req_a held and req_b raised -> gnt_a lasts exactly 8 cycles, 2 turnaround cycles follow, then gnt_b.
REQ-032 Macro undefined, same stimulus -> gnt_a stays high for 50+ cycles until req_a drops.
REQ-033 rst pulsed during GRANT_A and again during TURN -> all outputs 0 next edge; the following request behaves exactly as after power-on.
REQ-034 Random req stimulus for 10k cycles -> assert no dual grant, no grant while oe=0, and no dir change while oe=1.

Source files
------------

// File: rtl/bi_arb_pkg.sv
// rtl/bi_arb_pkg.sv - shared state encodings, direction constants and helpers for bi_bus_arbiter
package bi_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_TURN    = 2'd1,
      ST_GRANT_A = 2'd2,
      ST_GRANT_B = 2'd3
   } arb_state_t;

   localparam logic DIR_A = 1'b1;
   localparam logic DIR_B = 1'b0;

   // Wide enough for MAX_BURST up to 255 and TURN_CYCLES up to 15
   localparam int CNT_W = 8;

   function automatic arb_state_t grant_state(input logic d);
      return (d == DIR_A) ? ST_GRANT_A : ST_GRANT_B;
   endfunction

endpackage

// File: rtl/bi_arb_cnt.sv
// rtl/bi_arb_cnt.sv - loadable down-counter with zero flag, saturating at zero
module bi_arb_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/bi_bus_arbiter.sv
// rtl/bi_bus_arbiter.sv - two-sided shared-line arbiter with turnaround gaps; BI_ARB_BURST_LIMIT_EN enables burst-limited grants
module bi_bus_arbiter
   import bi_arb_pkg::*;
#(
   parameter int TURN_CYCLES = 2,
   parameter int MAX_BURST   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic req_a,
   input  logic req_b,
   output logic gnt_a,
   output logic gnt_b,
   output logic dir,
   output logic oe,
   output logic busy
);

   localparam logic [CNT_W-1:0] TURN_LOAD  = CNT_W'(TURN_CYCLES - 1);
   localparam logic [CNT_W-1:0] BURST_LOAD = CNT_W'(MAX_BURST - 1);

   arb_state_t       state_q, state_d;
   logic             dir_q, dir_d;
   logic             driven_q, driven_d;
   logic             last_b_q, last_b_d;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0] cnt_val;
   logic             go_turn, go_grant, tgt;
   logic             own_req, other_req;

   // Turnaround and burst never overlap in time, so one counter serves both
   bi_arb_cnt #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      driven_d  = driven_q;
      last_b_d  = last_b_q;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      cnt_val   = '0;
      go_turn   = 1'b0;
      go_grant  = 1'b0;
      tgt       = dir_q;
      own_req   = 1'b0;
      other_req = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_a || req_b) begin
               if (req_a && req_b) begin
                  tgt = last_b_q ? DIR_A : DIR_B;
               end else begin
                  tgt = req_a ? DIR_A : DIR_B;
               end
               // The line is never granted straight out of reset: the first owner always gets a turnaround
               if (driven_q && (tgt == dir_q)) begin
                  go_grant = 1'b1;
               end else begin
                  go_turn = 1'b1;
               end
            end
         end

         ST_TURN: begin
            cnt_dec = 1'b1;
            if (cnt_zero) begin
               if ((dir_q == DIR_A) ? req_a : req_b) begin
                  go_grant = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_GRANT_A, ST_GRANT_B: begin
            cnt_dec   = 1'b1;
            own_req   = (state_q == ST_GRANT_A) ? req_a : req_b;
            other_req = (state_q == ST_GRANT_A) ? req_b : req_a;
            tgt       = (state_q == ST_GRANT_A) ? DIR_B : DIR_A;
            if (!own_req) begin
               if (other_req) begin
                  go_turn = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
`ifdef BI_ARB_BURST_LIMIT_EN
            else if (cnt_zero && other_req) begin
               go_turn = 1'b1;
            end
`endif
         end

         default: state_d = ST_IDLE;
      endcase

      if (go_turn) begin
         state_d  = ST_TURN;
         dir_d    = tgt;
         cnt_load = 1'b1;
         cnt_val  = TURN_LOAD;
      end

      if (go_grant) begin
         state_d  = grant_state(tgt);
         dir_d    = tgt;
         driven_d = 1'b1;
         last_b_d = (tgt == DIR_B);
         cnt_load = 1'b1;
         cnt_val  = BURST_LOAD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         dir_q    <= DIR_B;
         driven_q <= 1'b0;
         last_b_q <= 1'b1;
         gnt_a    <= 1'b0;
         gnt_b    <= 1'b0;
         oe       <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         driven_q <= driven_d;
         last_b_q <= last_b_d;
         gnt_a    <= (state_d == ST_GRANT_A);
         gnt_b    <= (state_d == ST_GRANT_B);
         oe       <= (state_d == ST_GRANT_A) || (state_d == ST_GRANT_B);
      end
   end

   assign dir  = dir_q;
   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bi_bus_arbiter.sv
// tb/tb_bi_bus_arbiter.sv - self-checking bench for bi_bus_arbiter against a cycle-level reference model
module tb_bi_bus_arbiter;

   localparam int TURN = 2;
   localparam int MAXB = 8;
`ifdef BI_ARB_BURST_LIMIT_EN
   localparam bit BURST_EN = 1'b1;
`else
   localparam bit BURST_EN = 1'b0;
`endif

   logic clk;
   logic rst, req_a, req_b;
   logic gnt_a, gnt_b, dir, oe, busy;

   int n_cmp;
   int n_err;

   // Reference model: owner 0 = nobody, 1 = A, 2 = B; m_turn = turnaround cycles still to run
   int m_owner;
   int m_turn;
   bit m_dir;
   bit m_primed;
   int m_last;
   int m_run;

   bit   prev_oe, prev_dir;
   logic ra, rb;
   int   lat, run;
   bit   seen;

   bi_bus_arbiter #(.TURN_CYCLES(TURN), .MAX_BURST(MAXB)) dut (
      .clk   (clk),
      .rst   (rst),
      .req_a (req_a),
      .req_b (req_b),
      .gnt_a (gnt_a),
      .gnt_b (gnt_b),
      .dir   (dir),
      .oe    (oe),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs == exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner  = 0;
      m_turn   = 0;
      m_dir    = 1'b0;
      m_primed = 1'b0;
      m_last   = 2;
      m_run    = 0;
   endtask

   task automatic start_turn(input bit d);
      m_owner = 0;
      m_dir   = d;
      m_turn  = TURN;
   endtask

   task automatic give(input int side);
      m_owner  = side;
      m_dir    = (side == 1);
      m_primed = 1'b1;
      m_last   = side;
      m_run    = 1;
   endtask

   task automatic model_step(input logic a, input logic b);
      bit own, oth;
      int side, holder;
      if (m_turn > 0) begin
         m_turn--;
         if (m_turn == 0 && (m_dir ? a : b)) give(m_dir ? 1 : 2);
      end else if (m_owner != 0) begin
         holder = m_owner;
         own = (holder == 1) ? a : b;
         oth = (holder == 1) ? b : a;
         if (!own || (BURST_EN && m_run >= MAXB && oth)) begin
            m_owner = 0;
            if (oth) start_turn(holder == 2);
         end else begin
            m_run++;
         end
      end else if (a || b) begin
         if (a && b) side = (m_last == 2) ? 1 : 2;
         else side = a ? 1 : 2;
         if (m_primed && (m_dir == (side == 1))) give(side);
         else start_turn(side == 1);
      end
   endtask

   task automatic check_all();
      check("gnt_a", gnt_a, m_owner == 1);
      check("gnt_b", gnt_b, m_owner == 2);
      check("oe", oe, m_owner != 0);
      check("busy", busy, (m_owner != 0) || (m_turn > 0));
      check("dir", dir, m_dir);
      check("dual_grant", gnt_a & gnt_b, 1'b0);
      check("grant_without_oe", (gnt_a | gnt_b) & ~oe, 1'b0);
      check("dir_change_while_oe", prev_oe & oe & (dir ^ prev_dir), 1'b0);
      prev_oe  = oe;
      prev_dir = dir;
   endtask

   task automatic step(input logic a, input logic b);
      req_a = a;
      req_b = b;
      model_step(a, b);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;
   endtask

   task automatic wait_grant(input logic a, input logic b, input bit want_a, output int n);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step(a, b);
         n++;
         if (want_a ? gnt_a : gnt_b) break;
      end
   endtask

   initial begin
      #5_000_000;
      n_err++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      rst      = 1'b1;
      req_a    = 1'b0;
      req_b    = 1'b0;
      prev_oe  = 1'b0;
      prev_dir = 1'b0;
      model_reset();
      do_reset();

      // First request after reset always pays the turnaround
      wait_grant(1'b0, 1'b1, 1'b0, lat);
      check_int("first_b_latency", lat, 1 + TURN);
      step(1'b0, 1'b0);
      wait_grant(1'b0, 1'b1, 1'b0, lat);
      check_int("same_dir_latency", lat, 1);
      step(1'b0, 1'b0);

      // Simultaneous requests after reset: A wins, then hand-over to B
      do_reset();
      wait_grant(1'b1, 1'b1, 1'b1, lat);
      check_int("rr_a_first_latency", lat, 1 + TURN);
      wait_grant(1'b0, 1'b1, 1'b0, lat);
      check_int("handover_b_latency", lat, 1 + TURN);
      step(1'b0, 1'b0);

      // A holds its request while B waits
      do_reset();
      seen = 1'b0;
      run  = 0;
      for (int i = 0; i < 70; i++) begin
         step(1'b1, seen);
         if (gnt_a) begin
            seen = 1'b1;
            run++;
         end else if (seen) begin
            break;
         end
      end
      if (BURST_EN) begin
         check_int("burst_len", run, MAXB);
      end else begin
         check_int("hold_50_plus", int'(run >= 50), 1);
         step(1'b0, 1'b1);
      end
      wait_grant(1'b0, 1'b1, 1'b0, lat);
      check_int("turn_after_release", lat, TURN);
      step(1'b0, 1'b0);

      // Reset mid-grant and mid-turnaround
      do_reset();
      wait_grant(1'b1, 1'b0, 1'b1, lat);
      check_int("pre_reset_grant_latency", lat, 1 + TURN);
      step(1'b1, 1'b0);
      do_reset();
      check("rst_grant_gnt_a", gnt_a, 1'b0);
      step(1'b1, 1'b0);
      do_reset();
      check("rst_turn_busy", busy, 1'b0);
      wait_grant(1'b0, 1'b1, 1'b0, lat);
      check_int("post_reset_b_latency", lat, 1 + TURN);
      step(1'b0, 1'b0);

      // Random request traffic with sticky toggles and rare resets
      ra = 1'b0;
      rb = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 5) == 0) ra = ~ra;
         if ($urandom_range(0, 5) == 0) rb = ~rb;
         if ($urandom_range(0, 999) == 0) do_reset();
         else step(ra, rb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
